led_pattern_ctrl: RTL and testbench

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

---
 rtl/led_ctrl_pkg.sv | 13 +
 rtl/tick_gen.sv | 23 ++
 rtl/led_pattern_ctrl.sv | 166 ++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - mode encoding shared by the LED pattern controller
package led_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_MIRROR  = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider giving a one-cycle tick enable every TICK_DIV clocks
module tick_gen #(
  parameter int TICK_DIV = 4096
) (
  input  logic CLK,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!reset)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - two-button mode selector driving mirror/blink/chase/breathe LED patterns
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_LED         = 4,
  parameter int TICK_DIV      = 4096,
  parameter int LOCKOUT_TICKS = 16384,
  parameter int HALF_PERIOD   = 12207,
  parameter int PWM_BITS      = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              BUT1,
  input  logic              BUT2,
  output logic [N_LED-1:0]  LED,
  output logic [MODE_W-1:0] mode
);

  localparam int HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int LK_W  = $clog2(LOCKOUT_TICKS + 1);
  localparam int POS_W = $clog2(N_LED);

  localparam logic [HP_W-1:0]     HP_LAST  = HP_W'(HALF_PERIOD - 1);
  localparam logic [LK_W-1:0]     LK_MAX   = LK_W'(LOCKOUT_TICKS);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(N_LED - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK   (CLK),
    .reset (reset),
    .tick  (tick)
  );

  logic b1_meta, b1_sync, b2_meta, b2_sync;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      b1_meta <= 1'b1;
      b1_sync <= 1'b1;
      b2_meta <= 1'b1;
      b2_sync <= 1'b1;
    end else begin
      b1_meta <= BUT1;
      b1_sync <= b1_meta;
      b2_meta <= BUT2;
      b2_sync <= b2_meta;
    end
  end

  mode_t               mode_q, mode_d;
  logic [LK_W-1:0]     lock_q, lock_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic                phase_q, phase_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_down_q, dir_down_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                duty_down_q, duty_down_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                b1_prev_q, b1_prev_d;
  logic [N_LED-1:0]    led_d;
  logic                expired, change;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      mode_q      <= MODE_BLINK;
      lock_q      <= '0;
      hp_q        <= '0;
      phase_q     <= 1'b0;
      pos_q       <= '0;
      dir_down_q  <= 1'b0;
      duty_q      <= '0;
      duty_down_q <= 1'b0;
      pwm_q       <= '0;
      b1_prev_q   <= 1'b1;
      LED         <= '0;
    end else begin
      mode_q      <= mode_d;
      lock_q      <= lock_d;
      hp_q        <= hp_d;
      phase_q     <= phase_d;
      pos_q       <= pos_d;
      dir_down_q  <= dir_down_d;
      duty_q      <= duty_d;
      duty_down_q <= duty_down_d;
      pwm_q       <= pwm_d;
      b1_prev_q   <= b1_prev_d;
      LED         <= led_d;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    lock_d      = lock_q;
    hp_d        = hp_q;
    phase_d     = phase_q;
    pos_d       = pos_q;
    dir_down_d  = dir_down_q;
    duty_d      = duty_q;
    duty_down_d = duty_down_q;
    pwm_d       = pwm_q + PWM_BITS'(1);
    b1_prev_d   = b1_prev_q;
    expired     = (lock_q == LK_MAX);
    change      = tick && !b1_sync && !b2_sync && expired;

    if (tick) begin
      b1_prev_d = b1_sync;
      if (change) begin
        // pattern state restarts; chase direction deliberately survives
        mode_d      = mode_t'(mode_q + MODE_W'(1));
        lock_d      = '0;
        hp_d        = '0;
        phase_d     = 1'b0;
        pos_d       = '0;
        duty_d      = '0;
        duty_down_d = 1'b0;
      end else begin
        if (!expired) lock_d = lock_q + LK_W'(1);
        if (!b1_sync && b2_sync && b1_prev_q) dir_down_d = ~dir_down_q;

        if (hp_q == HP_LAST) begin
          hp_d    = '0;
          phase_d = ~phase_q;
          if (dir_down_q) pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
          else            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end else begin
          hp_d = hp_q + HP_W'(1);
        end

        if (!duty_down_q) begin
          if (duty_q == DUTY_MAX) begin
            duty_d      = duty_q - PWM_BITS'(1);
            duty_down_d = 1'b1;
          end else begin
            duty_d = duty_q + PWM_BITS'(1);
          end
        end else begin
          if (duty_q == '0) begin
            duty_d      = PWM_BITS'(1);
            duty_down_d = 1'b0;
          end else begin
            duty_d = duty_q - PWM_BITS'(1);
          end
        end
      end
    end

    led_d = '0;
    case (mode_q)
      MODE_MIRROR: begin
        led_d[0] = ~b1_sync;
        led_d[1] = ~b2_sync;
      end
      MODE_BLINK: begin
        for (int i = 0; i < N_LED; i++) led_d[i] = (i % 2 == 0) ? phase_q : ~phase_q;
      end
      MODE_CHASE:   led_d = N_LED'(1) << pos_q;
      MODE_BREATHE: led_d = {N_LED{pwm_q < duty_q}};
      default:      led_d = '0;
    endcase
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - directed vector bench for led_pattern_ctrl
module tb_led_pattern_ctrl;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       BUT1 = 1'b1;
  logic       BUT2 = 1'b1;
  logic [3:0] LED;
  logic [1:0] mode;

  led_pattern_ctrl #(
    .N_LED(4), .TICK_DIV(4), .LOCKOUT_TICKS(8), .HALF_PERIOD(3), .PWM_BITS(3)
  ) dut (
    .CLK(CLK), .reset(reset), .BUT1(BUT1), .BUT2(BUT2), .LED(LED), .mode(mode)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic       b1;
    logic       b2;
    logic       chk_led;
    logic [3:0] led;
    logic [1:0] md;
  } vec_t;

  vec_t tbl[$];
  int   cyc;
  int   n_pass;
  int   n_total;

  function automatic vec_t v(int c, logic b1, logic b2, logic chk, logic [3:0] l, logic [1:0] m);
    vec_t r;
    r.cyc = c; r.b1 = b1; r.b2 = b2; r.chk_led = chk; r.led = l; r.md = m;
    return r;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
  endtask

  // cyc counts rising edges since reset release; sampling happens on the falling edge
  task automatic step();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic do_reset(logic b1, logic b2);
    reset = 1'b0;
    BUT1  = b1;
    BUT2  = b2;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check("reset_led", {4'h0, LED}, 8'h00);
    check("reset_mode", {6'h0, mode}, 8'h01);
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic run_tbl(string name);
    for (int i = 0; i < tbl.size(); i++) begin
      BUT1 = tbl[i].b1;
      BUT2 = tbl[i].b2;
      while (cyc < tbl[i].cyc) step();
      check({name, "_mode"}, {6'h0, mode}, {6'h0, tbl[i].md});
      if (tbl[i].chk_led) check({name, "_led"}, {4'h0, LED}, {4'h0, tbl[i].led});
    end
    tbl.delete();
  endtask

  task automatic wait_led(string name, logic [3:0] exp);
    int n = 0;
    while (LED !== exp && n < 7) begin
      step();
      n++;
    end
    check(name, {4'h0, LED}, {4'h0, exp});
  endtask

  initial begin
    int k, t, d, p;
    logic [3:0] e;
    cyc = 0; n_pass = 0; n_total = 0;
    @(negedge CLK);

    // blink after reset, buttons idle
    do_reset(1'b1, 1'b1);
    tbl.push_back(v(1,  1, 1, 1, 4'b1010, 2'd1));
    tbl.push_back(v(12, 1, 1, 1, 4'b1010, 2'd1));
    tbl.push_back(v(13, 1, 1, 1, 4'b0101, 2'd1));
    tbl.push_back(v(24, 1, 1, 1, 4'b0101, 2'd1));
    tbl.push_back(v(25, 1, 1, 1, 4'b1010, 2'd1));
    tbl.push_back(v(37, 1, 1, 1, 4'b0101, 2'd1));
    tbl.push_back(v(40, 1, 1, 1, 4'b0101, 2'd1));
    run_tbl("blink");

    // both held: changes on ticks 9, 18, 27, then mirror
    do_reset(1'b0, 1'b0);
    tbl.push_back(v(35,  0, 0, 1, 4'b1010, 2'd1));
    tbl.push_back(v(36,  0, 0, 0, 4'b0000, 2'd2));
    tbl.push_back(v(37,  0, 0, 1, 4'b0001, 2'd2));
    tbl.push_back(v(71,  0, 0, 1, 4'b0100, 2'd2));
    tbl.push_back(v(72,  0, 0, 0, 4'b0000, 2'd3));
    tbl.push_back(v(73,  0, 0, 1, 4'b0000, 2'd3));
    tbl.push_back(v(107, 0, 0, 1, 4'b1111, 2'd3));
    tbl.push_back(v(108, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(v(109, 0, 0, 1, 4'b0011, 2'd0));
    tbl.push_back(v(112, 1, 1, 1, 4'b0000, 2'd0));
    tbl.push_back(v(120, 1, 0, 1, 4'b0010, 2'd0));
    tbl.push_back(v(124, 1, 1, 1, 4'b0000, 2'd0));
    run_tbl("hold");
    BUT1 = 1'b0;
    wait_led("mirror_press", 4'b0001);
    BUT1 = 1'b1;
    wait_led("mirror_release", 4'b0000);

    // chase with one BUT1 press at position 2
    do_reset(1'b0, 1'b0);
    tbl.push_back(v(36, 0, 0, 0, 4'b0000, 2'd2));
    tbl.push_back(v(37, 1, 1, 1, 4'b0001, 2'd2));
    tbl.push_back(v(48, 1, 1, 1, 4'b0001, 2'd2));
    tbl.push_back(v(49, 1, 1, 1, 4'b0010, 2'd2));
    tbl.push_back(v(61, 1, 1, 1, 4'b0100, 2'd2));
    tbl.push_back(v(62, 1, 1, 1, 4'b0100, 2'd2));
    tbl.push_back(v(66, 0, 1, 1, 4'b0100, 2'd2));
    tbl.push_back(v(72, 1, 1, 1, 4'b0100, 2'd2));
    tbl.push_back(v(73, 1, 1, 1, 4'b0010, 2'd2));
    tbl.push_back(v(85, 1, 1, 1, 4'b0001, 2'd2));
    tbl.push_back(v(97, 1, 1, 1, 4'b1000, 2'd2));
    run_tbl("chase");

    // reset mid-chase, then confirm fresh timing and upward direction
    reset = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("midreset_led", {4'h0, LED}, 8'h00);
    check("midreset_mode", {6'h0, mode}, 8'h01);
    reset = 1'b1;
    cyc   = 0;
    tbl.push_back(v(1,  1, 1, 1, 4'b1010, 2'd1));
    tbl.push_back(v(12, 1, 1, 1, 4'b1010, 2'd1));
    tbl.push_back(v(13, 1, 1, 1, 4'b0101, 2'd1));
    tbl.push_back(v(36, 0, 0, 0, 4'b0000, 2'd2));
    tbl.push_back(v(37, 1, 1, 1, 4'b0001, 2'd2));
    tbl.push_back(v(49, 1, 1, 1, 4'b0010, 2'd2));
    run_tbl("postreset");

    // breathe: triangle duty against free-running 3-bit pwm counter
    do_reset(1'b0, 1'b0);
    tbl.push_back(v(72, 0, 0, 0, 4'b0000, 2'd3));
    run_tbl("breathe_entry");
    BUT1 = 1'b1;
    BUT2 = 1'b1;
    for (int n = 73; n <= 140; n++) begin
      step();
      k = (n - 73) / 4;
      t = k % 14;
      d = (t <= 7) ? t : 14 - t;
      p = (n - 1) % 8;
      e = (p < d) ? 4'b1111 : 4'b0000;
      check("breathe_led", {4'h0, LED}, {4'h0, e});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
